fab_reset_sequencer: RTL and testbench
======================================

Name: fab_reset_sequencer

Overview:
- Power-up and restart sequencer between the MSS/CCC status outputs and the fabric logic (LED blinker, ISP restart block).
- Waits for a CCC lock and MSS ready, stretches reset, then releases the MSS fabric reset and the application reset in order.
- Services an ISP-complete request with a drain/restart handshake.
- Reports a sticky fault if lock never arrives.

Parameters:
- STRETCH_CYCLES, 1024: cycles that lock and ready must stay high before FAB_RESET_N releases.
- APP_DELAY, 64: cycles between FAB_RESET_N release and APP_RESET_N release.
- DRAIN_CYCLES, 256: cycles the application is held in reset before a restart pulse.
- RESTART_PULSE, 16: width of RESTART_REQ in cycles.
- LOCK_TIMEOUT, 1048576: cycles allowed in WAIT_LOCK before FAULT.

Ports:
- CLK  in  1  fabric clock (CCC GL0).
- RESET  in  1  synchronous, active-high reset.
- CCC_LOCK  in  1  CCC lock, asynchronous to CLK.
- MSS_READY  in  1  MSS ready, asynchronous to CLK.
- ISP_REQ  in  1  level request from MSS GPIO: programming finished, restart wanted.
- FAB_RESET_N  out  1  to MSS FAB_RESET_N, active-low.
- APP_RESET_N  out  1  to application logic (LED block), active-low.
- RESTART_REQ  out  1  pulse to the device-restart block.
- ISP_ACK  out  1  handshake acknowledge to MSS.
- FAULT  out  1  sticky lock-timeout flag.
- STATE  out  3  encoded current state, for LED/debug.

Behaviour:
- One clock, CLK. RESET is synchronous and active-high. All outputs are registered.
- Reset values: FAB_RESET_N=0, APP_RESET_N=0, RESTART_REQ=0, ISP_ACK=0, FAULT=0, STATE=HOLD(0). Counter is 0 and the synchronizers are cleared.
- CCC_LOCK, MSS_READY and ISP_REQ each pass through a 2-flop synchronizer; all decisions use the synced versions (2-cycle input latency). Define ok = lock_s & ready_s.
- Single shared down/up counter; width is clog2 of the largest parameter.
- States and encodings:
  - HOLD=0: next cycle go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK=1: both resets 0. If ok, go to STRETCH and clear the counter. Otherwise, when the counter reaches LOCK_TIMEOUT-1, go to FAULT.
  - STRETCH=2: if !ok, go back to WAIT_LOCK (counter cleared). When the counter reaches STRETCH_CYCLES-1, set FAB_RESET_N=1 and go to RELEASE.
  - RELEASE=3: if !ok, go to WAIT_LOCK with FAB_RESET_N=0. When the counter reaches APP_DELAY-1, set APP_RESET_N=1 and go to RUN.
  - RUN=4: if !ok, set both resets to 0 and go to WAIT_LOCK. Else if isp_s, set APP_RESET_N=0 and go to DRAIN. When !ok and isp_s occur in the same cycle, lock loss wins.
  - DRAIN=5: FAB_RESET_N stays 1. At count DRAIN_CYCLES-1, go to RESTART. Lock loss is ignored.
  - RESTART=6: RESTART_REQ=1 and ISP_ACK=1 for exactly RESTART_PULSE cycles, then go to ACK_WAIT with RESTART_REQ=0.
  - ACK_WAIT=7: ISP_ACK stays 1 until isp_s=0. Then ISP_ACK=0, FAB_RESET_N=0, go to HOLD (full re-sequence).
  - FAULT: STATE=1 and FAULT=1. Both resets held 0, no exit except RESET.
- Boundaries:
  - ISP_REQ dropping early during DRAIN/RESTART does not abort; the pulse completes, then ACK_WAIT exits on the next cycle.
  - ISP_REQ while not in RUN is ignored until RUN.
  - Lock bouncing during STRETCH restarts the full stretch.
  - RESET asserted mid-sequence forces the reset values on the next edge, including mid-pulse RESTART_REQ.
- Release latency from ok rising (synced) to FAB_RESET_N=1 is STRETCH_CYCLES+1 cycles; APP_RESET_N follows APP_DELAY cycles later.

Decomposition:
- Shared package holds:
  - the state enum/encoding constants (HOLD..ACK_WAIT), including the FAULT STATE value of 1;
  - the default timing constants.
- One natural sub-module: sync2, a 2-flop synchronizer instantiated three times.
- Counter and FSM stay in the top.

Test Plan:
All scenarios use STRETCH=8, APP_DELAY=4, DRAIN=4, PULSE=3, LOCK_TIMEOUT=64.
1. Power-up: RESET for 3 cycles, then CCC_LOCK=MSS_READY=1 -> FAB_RESET_N rises 2+1+8 cycles after inputs rise; APP_RESET_N rises 4 cycles later; STATE=4.
2. Lock glitch: drop CCC_LOCK for 1 cycle at stretch count 5 -> STATE returns to 1, FAB_RESET_N stays 0, and the full 8-cycle stretch restarts after re-lock.
3. ISP handshake: in RUN, raise ISP_REQ -> APP_RESET_N=0 3 cycles later (sync + register); after 4 drain cycles RESTART_REQ high for exactly 3 cycles; ISP_ACK high until ISP_REQ is dropped; then STATE=0, then re-sequence.
4. Timeout: hold CCC_LOCK=0 -> FAULT=1 after 64 WAIT_LOCK cycles and stays 1 when lock later rises; cleared only by RESET.
5. Collision: in RUN, drop CCC_LOCK and raise ISP_REQ on the same cycle -> STATE=1, RESTART_REQ never asserts, ISP_ACK=0.
6. Mid-pulse reset: assert RESET on the 2nd RESTART_REQ cycle -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fab_reset_sequencer_pkg.sv
// Shared definitions for the fabric reset sequencer: state encoding,
// the code reported on STATE while faulted, and default timing values.
package fab_reset_sequencer_pkg;

  // Internal states. The first eight map directly onto the 3-bit STATE
  // output. FAULT needs its own internal code because it reports as
  // WAIT_LOCK on STATE while also raising the sticky FAULT flag.
  typedef enum logic [3:0] {
    ST_HOLD      = 4'd0,
    ST_WAIT_LOCK = 4'd1,
    ST_STRETCH   = 4'd2,
    ST_RELEASE   = 4'd3,
    ST_RUN       = 4'd4,
    ST_DRAIN     = 4'd5,
    ST_RESTART   = 4'd6,
    ST_ACK_WAIT  = 4'd7,
    ST_FAULT     = 4'd8
  } seq_state_t;

  localparam logic [2:0] FAULT_STATE_CODE = 3'd1;

  localparam int DEFAULT_STRETCH_CYCLES = 1024;
  localparam int DEFAULT_APP_DELAY      = 64;
  localparam int DEFAULT_DRAIN_CYCLES   = 256;
  localparam int DEFAULT_RESTART_PULSE  = 16;
  localparam int DEFAULT_LOCK_TIMEOUT   = 1048576;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Map an internal state onto the externally visible 3-bit code.
  function automatic logic [2:0] state_code(input seq_state_t s);
    logic [2:0] code;
    if (s == ST_FAULT) begin
      code = FAULT_STATE_CODE;
    end else begin
      code = s[2:0];
    end
    return code;
  endfunction

endpackage

// File: rtl/fab_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module fab_reset_sequencer_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops; reset clears both stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fab_reset_sequencer.sv
// Power-up / restart sequencer sitting between the MSS/CCC status
// outputs and the fabric application logic. Waits for lock and ready,
// stretches reset, releases the MSS fabric reset and then the
// application reset, services ISP restart requests, and flags a sticky
// fault when lock never arrives.
module fab_reset_sequencer
  import fab_reset_sequencer_pkg::*;
#(
  parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
  parameter int APP_DELAY      = DEFAULT_APP_DELAY,
  parameter int DRAIN_CYCLES   = DEFAULT_DRAIN_CYCLES,
  parameter int RESTART_PULSE  = DEFAULT_RESTART_PULSE,
  parameter int LOCK_TIMEOUT   = DEFAULT_LOCK_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CCC_LOCK,
  input  logic       MSS_READY,
  input  logic       ISP_REQ,
  output logic       FAB_RESET_N,
  output logic       APP_RESET_N,
  output logic       RESTART_REQ,
  output logic       ISP_ACK,
  output logic       FAULT,
  output logic [2:0] STATE
);

  // One counter is shared by every timed state, so it is sized for the
  // longest interval.
  localparam int MAX_PARAM = max_of(max_of(max_of(STRETCH_CYCLES, APP_DELAY),
                                           max_of(DRAIN_CYCLES, RESTART_PULSE)),
                                    LOCK_TIMEOUT);
  localparam int CNT_W = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] APP_LAST     = CNT_W'(APP_DELAY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESTART_PULSE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);

  logic             lock_s;
  logic             ready_s;
  logic             isp_s;
  logic             ok;

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  logic             fab_next;
  logic             app_next;
  logic             req_next;
  logic             ack_next;
  logic             fault_next;
  logic [2:0]       code_next;

  fab_reset_sequencer_sync2 u_sync_lock (
    .clk   (CLK),
    .reset (RESET),
    .d     (CCC_LOCK),
    .q     (lock_s)
  );

  fab_reset_sequencer_sync2 u_sync_ready (
    .clk   (CLK),
    .reset (RESET),
    .d     (MSS_READY),
    .q     (ready_s)
  );

  fab_reset_sequencer_sync2 u_sync_isp (
    .clk   (CLK),
    .reset (RESET),
    .d     (ISP_REQ),
    .q     (isp_s)
  );

  assign ok = lock_s & ready_s;

  // Next-state and counter logic. Every transition restarts the counter
  // so each timed state counts from zero on entry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_ONE;
    case (state)
      ST_HOLD: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
      ST_WAIT_LOCK: begin
        if (ok) begin
          state_next = ST_STRETCH;
          cnt_next   = '0;
        end else if (cnt == LOCK_LAST) begin
          state_next = ST_FAULT;
          cnt_next   = '0;
        end
      end
      ST_STRETCH: begin
        if (!ok) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == STRETCH_LAST) begin
          state_next = ST_RELEASE;
          cnt_next   = '0;
        end
      end
      ST_RELEASE: begin
        if (!ok) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == APP_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!ok) begin
          state_next = ST_WAIT_LOCK;
        end else if (isp_s) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_next = ST_RESTART;
          cnt_next   = '0;
        end
      end
      ST_RESTART: begin
        if (cnt == PULSE_LAST) begin
          state_next = ST_ACK_WAIT;
          cnt_next   = '0;
        end
      end
      ST_ACK_WAIT: begin
        cnt_next = '0;
        if (!isp_s) begin
          state_next = ST_HOLD;
        end
      end
      ST_FAULT: begin
        cnt_next = cnt;
      end
      default: begin
        state_next = ST_HOLD;
        cnt_next   = '0;
      end
    endcase
  end

  // Decode the outputs from the state being entered so that they are
  // registered alongside the state and change on the same edge.
  always_comb begin
    fab_next   = 1'b0;
    app_next   = 1'b0;
    req_next   = 1'b0;
    ack_next   = 1'b0;
    fault_next = 1'b0;
    code_next  = state_code(state_next);
    case (state_next)
      ST_RELEASE: begin
        fab_next = 1'b1;
      end
      ST_RUN: begin
        fab_next = 1'b1;
        app_next = 1'b1;
      end
      ST_DRAIN: begin
        fab_next = 1'b1;
      end
      ST_RESTART: begin
        fab_next = 1'b1;
        req_next = 1'b1;
        ack_next = 1'b1;
      end
      ST_ACK_WAIT: begin
        fab_next = 1'b1;
        ack_next = 1'b1;
      end
      ST_FAULT: begin
        fault_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      FAB_RESET_N <= 1'b0;
      APP_RESET_N <= 1'b0;
      RESTART_REQ <= 1'b0;
      ISP_ACK     <= 1'b0;
      FAULT       <= 1'b0;
      STATE       <= 3'd0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      FAB_RESET_N <= fab_next;
      APP_RESET_N <= app_next;
      RESTART_REQ <= req_next;
      ISP_ACK     <= ack_next;
      FAULT       <= fault_next;
      STATE       <= code_next;
    end
  end

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Self-checking bench for fab_reset_sequencer: directed scenarios with
// literal latency expectations, then randomized input activity, all
// compared every cycle against a phase/dwell-time reference model.
module tb_fab_reset_sequencer;

  localparam int T_STRETCH = 8;
  localparam int T_APP     = 4;
  localparam int T_DRAIN   = 4;
  localparam int T_PULSE   = 3;
  localparam int T_TIMEOUT = 64;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       ccc_lock  = 1'b0;
  logic       mss_ready = 1'b0;
  logic       isp_req   = 1'b0;
  logic       fab_reset_n;
  logic       app_reset_n;
  logic       restart_req;
  logic       isp_ack;
  logic       fault;
  logic [2:0] state;
  logic [7:0] dut_vec;

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  fab_reset_sequencer #(
    .STRETCH_CYCLES (T_STRETCH),
    .APP_DELAY      (T_APP),
    .DRAIN_CYCLES   (T_DRAIN),
    .RESTART_PULSE  (T_PULSE),
    .LOCK_TIMEOUT   (T_TIMEOUT)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .CCC_LOCK    (ccc_lock),
    .MSS_READY   (mss_ready),
    .ISP_REQ     (isp_req),
    .FAB_RESET_N (fab_reset_n),
    .APP_RESET_N (app_reset_n),
    .RESTART_REQ (restart_req),
    .ISP_ACK     (isp_ack),
    .FAULT       (fault),
    .STATE       (state)
  );

  assign dut_vec = {fab_reset_n, app_reset_n, restart_req, isp_ack, fault, state};

  // Reference model: which phase of the sequence we are in and how long
  // we have dwelt there; inputs reach the decision two edges late.
  typedef enum int {PH_HOLD, PH_WAIT, PH_STRETCH, PH_RELEASE, PH_RUN,
                    PH_DRAIN, PH_RESTART, PH_ACK_WAIT, PH_FAULT} phase_t;

  phase_t     phase       = PH_HOLD;
  phase_t     next_phase  = PH_HOLD;
  int         dwell       = 0;
  bit         model_valid = 1'b0;
  bit         m_ok;
  bit         m_isp;
  bit         lock_hist  [0:1] = '{1'b0, 1'b0};
  bit         ready_hist [0:1] = '{1'b0, 1'b0};
  bit         isp_hist   [0:1] = '{1'b0, 1'b0};
  logic [2:0] spec_code  [0:8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};

  function automatic logic [7:0] model_vec();
    logic fab, app, req, ack, flt;
    fab = phase inside {PH_RELEASE, PH_RUN, PH_DRAIN, PH_RESTART, PH_ACK_WAIT};
    app = (phase == PH_RUN);
    req = (phase == PH_RESTART);
    ack = phase inside {PH_RESTART, PH_ACK_WAIT};
    flt = (phase == PH_FAULT);
    return {fab, app, req, ack, flt, spec_code[phase]};
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      phase       = PH_HOLD;
      dwell       = 0;
      lock_hist   = '{1'b0, 1'b0};
      ready_hist  = '{1'b0, 1'b0};
      isp_hist    = '{1'b0, 1'b0};
      model_valid = 1'b1;
    end else begin
      m_ok       = lock_hist[1] & ready_hist[1];
      m_isp      = isp_hist[1];
      dwell      = dwell + 1;
      next_phase = phase;
      case (phase)
        PH_HOLD:     next_phase = PH_WAIT;
        PH_WAIT:     if (m_ok) next_phase = PH_STRETCH;
                     else if (dwell >= T_TIMEOUT) next_phase = PH_FAULT;
        PH_STRETCH:  if (!m_ok) next_phase = PH_WAIT;
                     else if (dwell >= T_STRETCH) next_phase = PH_RELEASE;
        PH_RELEASE:  if (!m_ok) next_phase = PH_WAIT;
                     else if (dwell >= T_APP) next_phase = PH_RUN;
        PH_RUN:      if (!m_ok) next_phase = PH_WAIT;
                     else if (m_isp) next_phase = PH_DRAIN;
        PH_DRAIN:    if (dwell >= T_DRAIN) next_phase = PH_RESTART;
        PH_RESTART:  if (dwell >= T_PULSE) next_phase = PH_ACK_WAIT;
        PH_ACK_WAIT: if (!m_isp) next_phase = PH_HOLD;
        default:     next_phase = phase;
      endcase
      if (next_phase != phase) begin
        phase = next_phase;
        dwell = 0;
      end
      lock_hist[1]  = lock_hist[0];
      lock_hist[0]  = ccc_lock;
      ready_hist[1] = ready_hist[0];
      ready_hist[0] = mss_ready;
      isp_hist[1]   = isp_hist[0];
      isp_hist[0]   = isp_req;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Compare every registered output against the model once per cycle.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
    end
  end

  task automatic applyStimulus(input logic l, input logic r, input logic i, input logic rst);
    @(negedge clk);
    ccc_lock  = l;
    mss_ready = r;
    isp_req   = i;
    reset     = rst;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Count edges until output bit bit_idx reaches level, for DUT and model.
  task automatic wait_level(input int bit_idx, input logic level, input int limit,
                            output int dut_edges, output int model_edges);
    logic [7:0] mv;
    dut_edges   = -1;
    model_edges = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      mv = model_vec();
      if (dut_edges < 0 && dut_vec[bit_idx] === level) dut_edges = i;
      if (model_edges < 0 && mv[bit_idx] == level) model_edges = i;
      if (dut_edges >= 0 && model_edges >= 0) break;
    end
  endtask

  task automatic check_latency(input string name, input int d, input int m, input int expected);
    checkOutput({name, "_dut"}, d, expected);
    checkOutput({name, "_model"}, m, expected);
  endtask

  initial begin
    int   d, m, cnt_hi;
    int   lock_left, ready_left, isp_left, rst_left;
    logic r_lock, r_ready, r_isp, r_rst;

    // Reset for three cycles.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_state", 32'(dut_vec), 32'h0);
    checkOutput("reset_state_model", 32'(model_vec()), 32'h0);

    // Power-up: lock and ready rise together with reset release.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_level(7, 1'b1, 40, d, m);
    check_latency("fab_release", d, m, 11);
    wait_level(6, 1'b1, 20, d, m);
    check_latency("app_release", d, m, 4);
    checkOutput("run_state", 32'(state), 32'd4);

    // ISP handshake.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    wait_level(6, 1'b0, 20, d, m);
    check_latency("isp_app_drop", d, m, 3);
    wait_level(5, 1'b1, 20, d, m);
    check_latency("drain_len", d, m, 4);
    cnt_hi = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (restart_req === 1'b1) cnt_hi++;
      else break;
    end
    checkOutput("pulse_width", cnt_hi, 3);
    repeat (3) tick();
    checkOutput("ack_held", 32'(isp_ack), 32'd1);
    checkOutput("ack_wait_state", 32'(state), 32'd7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_level(4, 1'b0, 20, d, m);
    check_latency("ack_drop", d, m, 3);
    checkOutput("hold_state", 32'(state), 32'd0);
    wait_level(7, 1'b1, 30, d, m);
    check_latency("resequence_fab", d, m, 10);
    wait_level(6, 1'b1, 20, d, m);
    check_latency("resequence_app", d, m, 4);

    // Lock glitch at stretch count 5 restarts the full stretch.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("lock_lost_state", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("glitch_state", 32'(state), 32'd1);
    checkOutput("glitch_fab", 32'(fab_reset_n), 32'd0);
    wait_level(7, 1'b1, 30, d, m);
    check_latency("restretch", d, m, 9);
    wait_level(6, 1'b1, 20, d, m);
    check_latency("restretch_app", d, m, 4);

    // Lock loss and ISP request in the same cycle: lock loss wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    cnt_hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (restart_req !== 1'b0 || isp_ack !== 1'b0) cnt_hi++;
    end
    checkOutput("collision_no_restart", cnt_hi, 0);
    checkOutput("collision_state", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_level(6, 1'b1, 40, d, m);
    check_latency("relock_app", d, m, 15);

    // Reset during the second RESTART_REQ cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    wait_level(5, 1'b1, 20, d, m);
    check_latency("restart_rise", d, m, 7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("midpulse_reset", 32'(dut_vec), 32'h0);

    // Lock timeout and sticky fault.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    wait_level(3, 1'b1, 100, d, m);
    check_latency("lock_timeout", d, m, 65);
    checkOutput("fault_state", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (12) tick();
    checkOutput("fault_sticky", 32'(dut_vec), 32'h09);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("fault_cleared", 32'(dut_vec), 32'h0);

    // Randomized activity, checked cycle by cycle against the model.
    lock_left  = 0;
    ready_left = 0;
    isp_left   = 0;
    rst_left   = 0;
    r_lock     = 1'b1;
    r_ready    = 1'b1;
    r_isp      = 1'b0;
    r_rst      = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (lock_left == 0) begin
        r_lock = ($urandom_range(0, 99) < 80);
        if (r_lock) lock_left = $urandom_range(10, 120);
        else if ($urandom_range(0, 9) == 0) lock_left = $urandom_range(60, 90);
        else lock_left = $urandom_range(1, 6);
      end else begin
        lock_left--;
      end
      if (ready_left == 0) begin
        r_ready    = ($urandom_range(0, 99) < 90);
        ready_left = r_ready ? $urandom_range(10, 150) : $urandom_range(1, 4);
      end else begin
        ready_left--;
      end
      if (isp_left == 0) begin
        r_isp    = ($urandom_range(0, 1) == 1);
        isp_left = $urandom_range(1, 40);
      end else begin
        isp_left--;
      end
      if (rst_left > 0) begin
        rst_left--;
        r_rst = 1'b1;
      end else begin
        r_rst = ($urandom_range(0, 299) == 0);
        if (r_rst) rst_left = $urandom_range(0, 2);
      end
      applyStimulus(r_lock, r_ready, r_isp, r_rst);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
